// File: rtl/mem_arb2.sv
// Two-port round-robin arbiter in front of a single-port synchronous memory.
// Issues at most one command per cycle and steers one-cycle read data back to its issuer.
module mem_arb2 #(
  parameter int WORD = 32,
  parameter int ADDR = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0,
  input  logic            req1,
  input  logic            we0,
  input  logic            we1,
  input  logic [ADDR-1:0] addr0,
  input  logic [ADDR-1:0] addr1,
  input  logic [WORD-1:0] wdata0,
  input  logic [WORD-1:0] wdata1,
  output logic            gnt0,
  output logic            gnt1,
  output logic            rvalid0,
  output logic            rvalid1,
  output logic [WORD-1:0] rdata0,
  output logic [WORD-1:0] rdata1,
  output logic [ADDR-1:0] mem_A,
  output logic            mem_W,
  output logic [WORD-1:0] mem_D,
  input  logic [WORD-1:0] mem_Q
);

  logic last;
  logic rd_pend;
  logic rd_port;
  logic grant;

  // Under contention the port that did not win last time is favoured.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      if (req0 && req1) begin
        gnt0 = last;
        gnt1 = ~last;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  assign grant = gnt0 | gnt1;

  always_comb begin
    mem_A = '0;
    mem_W = 1'b0;
    mem_D = '0;
    if (gnt0) begin
      mem_A = addr0;
      mem_W = we0;
      mem_D = wdata0;
    end else if (gnt1) begin
      mem_A = addr1;
      mem_W = we1;
      mem_D = wdata1;
    end
  end

  // rd_port keeps its value on idle cycles; only rd_pend qualifies it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last    <= 1'b1;
      rd_pend <= 1'b0;
      rd_port <= 1'b0;
    end else begin
      rd_pend <= grant & ~mem_W;
      if (grant) begin
        last    <= gnt1;
        rd_port <= gnt1;
      end
    end
  end

  assign rvalid0 = rd_pend & ~rd_port;
  assign rvalid1 = rd_pend & rd_port;
  assign rdata0  = mem_Q;
  assign rdata1  = mem_Q;

endmodule
